ppu_oam_ctrl: RTL and testbench
===============================

Name: ppu_oam_ctrl

Overview:
Owns the 256x8 primary OAM and arbitrates its single port between three requesters: the CPU register interface ($2003 OAMADDR, $2004 OAMDATA), the $4014 OAM DMA engine, and the sprite evaluator/fetch logic during rendering. It contains the OAMADDR register, the DMA sequencer that stalls the CPU and copies one 256-byte CPU page into OAM, and the rendering-window rules that lock the CPU out of OAM. It sits in the PPU between the CPU bus decode and the sprite unit.

Parameters:
VIS_LINES, 240, number of visible scanlines (0..VIS_LINES-1).
PRE_LINE, 261, index of the pre-render scanline.

Ports:
clk  in  1  clock
reset  in  1  reset (asynchronous, active-high)
cpu_ce  in  1  one-cycle CPU clock enable; all CPU and DMA actions advance only when this is high
cpu_odd  in  1  high when the current CPU cycle is odd (used for DMA alignment)
reg_sel  in  2  00=$2003, 01=$2004, 10=$4014, 11=none
reg_wr  in  1  register write strobe, qualified by cpu_ce
reg_rd  in  1  register read strobe, qualified by cpu_ce
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  OAMDATA read value
cpu_stall  out  1  halts the CPU while DMA is active
dma_addr  out  16  CPU bus address for DMA reads
dma_rd  out  1  DMA bus read strobe
dma_data  in  8  CPU bus read data, valid in the same cycle as dma_rd
render_en  in  1  logical OR of background and sprite enables from PPUMASK
scanline  in  10  current scanline
x_idx  in  10  current dot
eval_addr  in  8  sprite unit OAM address
eval_data  out  8  OAM read data to the sprite unit
oam_addr  out  8  OAM RAM address
oam_we  out  1  OAM RAM write enable
oam_wdata  out  8  OAM RAM write data
oam_rdata  in  8  OAM RAM read data (combinational read)

Behaviour:
- Reset values: oamaddr=0, DMA state D_IDLE, cpu_stall=0, dma_rd=0, dma_addr=0, oam_we=0, oam_wdata=0, cpu_rdata=0.
- rendering = render_en && (scanline < VIS_LINES || scanline == PRE_LINE).
- OAM port mux: when rendering, oam_addr = eval_addr, and all CPU and DMA writes are suppressed (oam_we=0). Otherwise oam_addr = oamaddr. eval_data = oam_rdata at all times.
- $2003 write: oamaddr <= cpu_wdata.
- $2004 write outside rendering: write cpu_wdata to oam[oamaddr], then oamaddr <= oamaddr+1, wrapping 255 to 0.
- $2004 write during rendering: no OAM write; oamaddr <= oamaddr + 4 (low 2 bits preserved, 8-bit wrap).
- $2004 read: cpu_rdata <= oam_rdata at the current mux address. No increment.
- OAMADDR clear: when rendering and 257 <= x_idx <= 320, oamaddr <= 0 on every clk. This has priority over CPU writes.
- DMA FSM, advancing on cpu_ce only:
  - D_IDLE: a $4014 write latches page <= cpu_wdata, clears the byte counter i, and moves to D_HALT.
  - D_HALT: 1 cycle. Goes to D_ALIGN if cpu_odd, else to D_READ.
  - D_ALIGN: 1 cycle, then D_READ.
  - D_READ: dma_addr={page,i}, dma_rd=1, latch dma_data, then D_WRITE.
  - D_WRITE: behaves exactly as a $2004 write of the latched byte (including the rendering rules). Then i <= i+1; if i==255 go to D_IDLE, else D_READ.
  - Total stall is 513 cycles (even start) or 514 (odd start).
- cpu_stall=1 in every state other than D_IDLE. It is asserted from the cpu_ce cycle after the $4014 write.
- CPU register accesses arriving while cpu_stall=1 are ignored.
- A second $4014 write during DMA is ignored.
- Reset mid-DMA returns to D_IDLE immediately. Bytes already written stay in OAM.
- Same-cycle priority: OAMADDR clear > DMA write > CPU $2004/$2003 access.

Optional Feature:
OAM_ATTR_MASK_EN:
- Defined: any write to an address with addr[1:0]==2 (CPU or DMA) stores data with bits 4:2 forced to 0, so reads return those bits as 0.
- Undefined: all 8 bits are stored as written.

Test Plan:
- $2003=0x10; $2004 writes 0xAA, 0xBB outside rendering -> oam[0x10]=0xAA, oam[0x11]=0xBB, oamaddr=0x12; $2003=0x10 then $2004 read -> cpu_rdata=0xAA.
- $2003=0xFF; $2004 write 0x5C -> oam[0xFF]=0x5C, oamaddr wraps to 0x00.
- $4014=0x02 on an even cycle with CPU memory 0x0200+i = i^0x3C, oamaddr=0 -> cpu_stall high for exactly 513 cpu_ce cycles; oam[i]=i^0x3C for all i; dma_addr sweeps 0x0200..0x02FF.
- Same DMA started on an odd cycle with oamaddr=0x80 -> 514-cycle stall; oam[(0x80+i)&0xFF]=mem[0x0200+i].
- render_en=1, scanline=100, oamaddr=0x05: $2004 write 0x77 -> no oam_we, oamaddr=0x09; at x_idx=257 -> oamaddr=0; oam_addr tracks eval_addr throughout.
- With OAM_ATTR_MASK_EN: $2003=0x02, $2004 write 0xFF -> oam[0x02]=0xE3; without the macro -> 0xFF.

Source files
------------

// File: rtl/ppu_oam_ctrl.sv
// ppu_oam_ctrl: owner of the primary OAM port.
// Arbitrates the OAM RAM between the CPU register interface ($2003/$2004),
// the $4014 page DMA engine and the sprite evaluator during rendering.
// Holds OAMADDR, the DMA sequencer that stalls the CPU for one 256-byte
// page copy, and the rendering-window lockout / OAMADDR clear rules.
//
// Build option:
//   OAM_ATTR_MASK_EN - when defined, every write to an attribute byte
//   (address bits [1:0] == 2) stores the data with bits 4:2 cleared.
//   When undefined, all eight bits are stored as written.

module ppu_oam_ctrl #(
    parameter int VIS_LINES = 240,
    parameter int PRE_LINE  = 261
) (
    input  logic        clk,
    input  logic        reset,
    // CPU side
    input  logic        cpu_ce,
    input  logic        cpu_odd,
    input  logic [1:0]  reg_sel,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_stall,
    // DMA bus master
    output logic [15:0] dma_addr,
    output logic        dma_rd,
    input  logic [7:0]  dma_data,
    // Rendering context
    input  logic        render_en,
    input  logic [9:0]  scanline,
    input  logic [9:0]  x_idx,
    // Sprite unit
    input  logic [7:0]  eval_addr,
    output logic [7:0]  eval_data,
    // OAM RAM port
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata
);

    localparam logic [9:0] VIS_END  = 10'(VIS_LINES);
    localparam logic [9:0] PRE_IDX  = 10'(PRE_LINE);
    localparam logic [9:0] CLR_LO   = 10'd257;
    localparam logic [9:0] CLR_HI   = 10'd320;

    localparam logic [1:0] SEL_OAMADDR = 2'b00;
    localparam logic [1:0] SEL_OAMDATA = 2'b01;
    localparam logic [1:0] SEL_OAMDMA  = 2'b10;

    typedef enum logic [2:0] {
        D_IDLE,
        D_HALT,
        D_ALIGN,
        D_READ,
        D_WRITE
    } dma_state_t;

    dma_state_t state, state_next;

    logic [7:0] oamaddr;     // OAMADDR register
    logic [7:0] dma_page;    // high byte of the DMA source address
    logic [7:0] dma_idx;     // byte counter within the page
    logic [7:0] dma_byte;    // byte captured in D_READ, written in D_WRITE

    logic       rendering;
    logic       oamaddr_clear;
    logic       cpu_access_ok;
    logic       cpu_wr_addr;
    logic       cpu_wr_data;
    logic       cpu_rd_data;
    logic       dma_start;
    logic       dma_wr_go;
    logic [7:0] wr_byte;

    // Rendering window and CPU register decode; CPU accesses only count while the DMA is idle.
    always_comb begin
        rendering     = render_en && ((scanline < VIS_END) || (scanline == PRE_IDX));
        oamaddr_clear = rendering && (x_idx >= CLR_LO) && (x_idx <= CLR_HI);
        cpu_access_ok = cpu_ce && (state == D_IDLE);
        cpu_wr_addr   = cpu_access_ok && reg_wr && (reg_sel == SEL_OAMADDR);
        cpu_wr_data   = cpu_access_ok && reg_wr && (reg_sel == SEL_OAMDATA);
        cpu_rd_data   = cpu_access_ok && reg_rd && (reg_sel == SEL_OAMDATA);
        dma_start     = cpu_access_ok && reg_wr && (reg_sel == SEL_OAMDMA);
    end

    // DMA state register.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= D_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DMA next-state logic and bus outputs; all transitions wait for cpu_ce.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        cpu_stall  = (state != D_IDLE);
        dma_rd     = 1'b0;
        dma_addr   = 16'h0000;
        dma_wr_go  = 1'b0;

        case (state)
            D_IDLE: begin
                if (dma_start) begin
                    state_next = D_HALT;
                end
            end

            D_HALT: begin
                if (cpu_ce) begin
                    state_next = cpu_odd ? D_ALIGN : D_READ;
                end
            end

            D_ALIGN: begin
                if (cpu_ce) begin
                    state_next = D_READ;
                end
            end

            D_READ: begin
                dma_addr = {dma_page, dma_idx};
                dma_rd   = cpu_ce;
                if (cpu_ce) begin
                    state_next = D_WRITE;
                end
            end

            D_WRITE: begin
                dma_wr_go = cpu_ce;
                if (cpu_ce) begin
                    state_next = (dma_idx == 8'hFF) ? D_IDLE : D_READ;
                end
            end

            default: begin
                state_next = D_IDLE;
            end
        endcase
    end

    // DMA datapath: page latch, byte counter and captured read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_page <= 8'h00;
            dma_idx  <= 8'h00;
            dma_byte <= 8'h00;
        end else begin
            if (dma_start) begin
                dma_page <= cpu_wdata;
                dma_idx  <= 8'h00;
            end
            if ((state == D_READ) && cpu_ce) begin
                dma_byte <= dma_data;
            end
            if (dma_wr_go) begin
                dma_idx <= dma_idx + 8'd1;
            end
        end
    end

    // OAMADDR: the sprite-fetch clear wins, then a DMA write, then CPU accesses.
    // A data write during rendering skips to the next sprite (+4) instead of writing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oamaddr <= 8'h00;
        end else if (oamaddr_clear) begin
            oamaddr <= 8'h00;
        end else if (dma_wr_go || cpu_wr_data) begin
            oamaddr <= rendering ? (oamaddr + 8'd4) : (oamaddr + 8'd1);
        end else if (cpu_wr_addr) begin
            oamaddr <= cpu_wdata;
        end
    end

    // OAMDATA read register, sampled from whatever address the port mux selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata <= 8'h00;
        end else if (cpu_rd_data) begin
            cpu_rdata <= oam_rdata;
        end
    end

    // OAM port mux: the sprite unit owns the address while rendering and all writes are blocked.
    always_comb begin
        wr_byte = dma_wr_go ? dma_byte : cpu_wdata;
`ifdef OAM_ATTR_MASK_EN
        if (oamaddr[1:0] == 2'd2) begin
            wr_byte[4:2] = 3'b000;
        end
`endif
        oam_addr  = rendering ? eval_addr : oamaddr;
        oam_we    = !reset && !rendering && (dma_wr_go || cpu_wr_data);
        oam_wdata = oam_we ? wr_byte : 8'h00;
    end

    assign eval_data = oam_rdata;

endmodule

// File: tb/tb_ppu_oam_ctrl.sv
// tb_ppu_oam_ctrl: self-checking bench for ppu_oam_ctrl.
// Models the OAM RAM and the CPU page memory, applies a table of register
// vectors and runs the DMA / reset corner sequences. Honours OAM_ATTR_MASK_EN.

module tb_ppu_oam_ctrl;

    localparam int VIS_LINES = 240;
    localparam int PRE_LINE  = 261;

`ifdef OAM_ATTR_MASK_EN
    localparam logic [7:0] ATTR_FF = 8'hE3;
`else
    localparam logic [7:0] ATTR_FF = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ce;
    logic        cpu_odd;
    logic [1:0]  reg_sel;
    logic        reg_wr;
    logic        reg_rd;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_stall;
    logic [15:0] dma_addr;
    logic        dma_rd;
    logic [7:0]  dma_data;
    logic        render_en;
    logic [9:0]  scanline;
    logic [9:0]  x_idx;
    logic [7:0]  eval_addr;
    logic [7:0]  eval_data;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata;
    logic [7:0]  oam_rdata;

    int checks = 0;
    int errors = 0;

    ppu_oam_ctrl #(.VIS_LINES(VIS_LINES), .PRE_LINE(PRE_LINE)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_ce    (cpu_ce),
        .cpu_odd   (cpu_odd),
        .reg_sel   (reg_sel),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dma_addr  (dma_addr),
        .dma_rd    (dma_rd),
        .dma_data  (dma_data),
        .render_en (render_en),
        .scanline  (scanline),
        .x_idx     (x_idx),
        .eval_addr (eval_addr),
        .eval_data (eval_data),
        .oam_addr  (oam_addr),
        .oam_we    (oam_we),
        .oam_wdata (oam_wdata),
        .oam_rdata (oam_rdata)
    );

    always #5 clk = ~clk;

    // OAM RAM model: combinational read, write on the clock edge.
    logic [7:0] oam_mem [256];
    logic       clr_mem = 1'b0;

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 256; k++) oam_mem[k] <= 8'h00;
        end else if (oam_we) begin
            oam_mem[oam_addr] <= oam_wdata;
        end
    end

    assign oam_rdata = oam_mem[oam_addr];
    // CPU page memory: byte i of page 0x02 holds i ^ 0x3C.
    assign dma_data  = dma_addr[7:0] ^ 8'h3C ^ (dma_addr[15:8] ^ 8'h02);

    // Scoreboards: expected OAMDATA reads and expected DMA source addresses.
    logic [7:0]  rd_q[$];
    logic [15:0] addr_q[$];

    typedef struct {
        string      name;
        logic       ce;
        logic [1:0] sel;
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic       ren;
        logic [9:0] line;
        logic [9:0] dot;
        logic [7:0] eval;
        logic [7:0] exp_addr;
        logic       exp_we;
        logic [7:0] exp_wd;
        logic       rdchk;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic ce, input logic [1:0] sel, input logic wr,
                       input logic rd, input logic [7:0] wd, input logic ren, input logic [9:0] line,
                       input logic [9:0] dot, input logic [7:0] ev, input logic [7:0] ea,
                       input logic ewe, input logic [7:0] ewd, input logic rc, input logic [7:0] erd);
        vec_t v;
        v.name = n; v.ce = ce; v.sel = sel; v.wr = wr; v.rd = rd; v.wdata = wd;
        v.ren = ren; v.line = line; v.dot = dot; v.eval = ev;
        v.exp_addr = ea; v.exp_we = ewe; v.exp_wd = ewd; v.rdchk = rc; v.exp_rd = erd;
        vecs.push_back(v);
    endtask

    task automatic idle();
        cpu_ce    = 1'b1;
        reg_sel   = 2'b11;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        cpu_wdata = 8'h00;
        render_en = 1'b0;
        scanline  = 10'd0;
        x_idx     = 10'd0;
        eval_addr = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] sel, input logic [7:0] data);
        idle();
        reg_sel   = sel;
        reg_wr    = 1'b1;
        cpu_wdata = data;
        tick();
        idle();
    endtask

    task automatic clear_ram();
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
    endtask

    // Full page DMA from page 0x02 with OAMADDR preset to start_addr.
    task automatic run_dma(input string name, input logic odd, input logic [7:0] start_addr,
                           input bit ce_gaps, input int exp_stall);
        int  stall_cnt;
        int  extra;
        int  bad;
        bit  done;
        logic [7:0] exp_b;

        write_reg(2'b00, start_addr);
        clear_ram();
        cpu_odd = odd;
        addr_q.delete();
        for (int i = 0; i < 256; i++) addr_q.push_back(16'h0200 + 16'(i));

        reg_sel   = 2'b10;
        reg_wr    = 1'b1;
        cpu_wdata = 8'h02;
        #1;
        check({name, "_stall_on_write"}, cpu_stall, 1'b0);
        tick();

        stall_cnt = 0;
        extra     = 0;
        done      = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle();
            cpu_ce = ce_gaps ? ((cyc % 4) != 3) : 1'b1;
            if (cyc == 100) begin
                reg_sel = 2'b00; reg_wr = 1'b1; cpu_wdata = 8'h33;
            end
            if (cyc == 201) begin
                reg_sel = 2'b10; reg_wr = 1'b1; cpu_wdata = 8'h05;
            end
            #1;
            if (!cpu_stall) begin
                done = 1;
                break;
            end
            if (cpu_ce) stall_cnt++;
            if (dma_rd && cpu_ce) begin
                if (addr_q.size() == 0) extra++;
                else check({name, "_dma_addr"}, dma_addr, addr_q.pop_front());
            end
            tick();
        end

        check({name, "_finished"}, 16'(done), 16'd1);
        check({name, "_stall_cycles"}, 16'(stall_cnt), 16'(exp_stall));
        check({name, "_extra_reads"}, 16'(extra), 16'd0);
        check({name, "_missing_reads"}, 16'(addr_q.size()), 16'd0);

        bad = 0;
        for (int j = 0; j < 256; j++) begin
            exp_b = (8'(j) - start_addr) ^ 8'h3C;
            if (oam_mem[j] !== exp_b) begin
                if (bad == 0) $display("FAIL %s_oam[%0d]: got %h want %h", name, j, oam_mem[j], exp_b);
                bad++;
            end
        end
        check({name, "_oam_bad_bytes"}, 16'(bad), 16'd0);
        check({name, "_oamaddr_wrapped"}, oam_addr, start_addr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int reads;

        idle();
        cpu_odd = 1'b0;
        reset   = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_cpu_stall", cpu_stall, 1'b0);
        check("rst_dma_rd", dma_rd, 1'b0);
        check("rst_dma_addr", dma_addr, 16'h0000);
        check("rst_oam_we", oam_we, 1'b0);
        check("rst_oam_wdata", oam_wdata, 8'h00);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_oam_addr", oam_addr, 8'h00);
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        //   name               ce sel    wr rd wdata  ren line    dot     eval   e_addr e_we e_wd   rdc e_rd
        add("w2003_10",         1, 2'd0, 1, 0, 8'h10, 0, 10'd0,   10'd0,   8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        add("w2004_AA",         1, 2'd1, 1, 0, 8'hAA, 0, 10'd0,   10'd0,   8'h00, 8'h10, 1, 8'hAA, 0, 8'h00);
        add("w2004_BB",         1, 2'd1, 1, 0, 8'hBB, 0, 10'd0,   10'd0,   8'h00, 8'h11, 1, 8'hBB, 0, 8'h00);
        add("w2003_10b",        1, 2'd0, 1, 0, 8'h10, 0, 10'd0,   10'd0,   8'h00, 8'h12, 0, 8'h00, 0, 8'h00);
        add("r2004_AA",         1, 2'd1, 0, 1, 8'h00, 0, 10'd0,   10'd0,   8'h00, 8'h10, 0, 8'h00, 1, 8'hAA);
        add("ce_low_w2004",     0, 2'd1, 1, 0, 8'h55, 0, 10'd0,   10'd0,   8'h00, 8'h10, 0, 8'h00, 0, 8'h00);
        add("w2003_FF",         1, 2'd0, 1, 0, 8'hFF, 0, 10'd0,   10'd0,   8'h00, 8'h10, 0, 8'h00, 0, 8'h00);
        add("w2004_5C",         1, 2'd1, 1, 0, 8'h5C, 0, 10'd0,   10'd0,   8'h00, 8'hFF, 1, 8'h5C, 0, 8'h00);
        add("w2003_FF_wrap",    1, 2'd0, 1, 0, 8'hFF, 0, 10'd0,   10'd0,   8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        add("r2004_5C",         1, 2'd1, 0, 1, 8'h00, 0, 10'd0,   10'd0,   8'h00, 8'hFF, 0, 8'h00, 1, 8'h5C);
        add("w2003_11",         1, 2'd0, 1, 0, 8'h11, 0, 10'd0,   10'd0,   8'h00, 8'hFF, 0, 8'h00, 0, 8'h00);
        add("r2004_BB",         1, 2'd1, 0, 1, 8'h00, 0, 10'd0,   10'd0,   8'h00, 8'h11, 0, 8'h00, 1, 8'hBB);
        add("w2003_02",         1, 2'd0, 1, 0, 8'h02, 0, 10'd0,   10'd0,   8'h00, 8'h11, 0, 8'h00, 0, 8'h00);
        add("w2004_attr",       1, 2'd1, 1, 0, 8'hFF, 0, 10'd0,   10'd0,   8'h00, 8'h02, 1, ATTR_FF, 0, 8'h00);
        add("w2003_02b",        1, 2'd0, 1, 0, 8'h02, 0, 10'd0,   10'd0,   8'h00, 8'h03, 0, 8'h00, 0, 8'h00);
        add("r2004_attr",       1, 2'd1, 0, 1, 8'h00, 0, 10'd0,   10'd0,   8'h00, 8'h02, 0, 8'h00, 1, ATTR_FF);
        add("w2003_05",         1, 2'd0, 1, 0, 8'h05, 0, 10'd0,   10'd0,   8'h00, 8'h02, 0, 8'h00, 0, 8'h00);
        add("rend_w2004_77",    1, 2'd1, 1, 0, 8'h77, 1, 10'd100, 10'd0,   8'h3A, 8'h3A, 0, 8'h00, 0, 8'h00);
        add("rend_r2004_eval",  1, 2'd1, 0, 1, 8'h00, 1, 10'd100, 10'd0,   8'h10, 8'h10, 0, 8'h00, 1, 8'hAA);
        add("rend_exit_plus4",  1, 2'd3, 0, 0, 8'h00, 0, 10'd100, 10'd0,   8'h00, 8'h09, 0, 8'h00, 0, 8'h00);
        add("preline_w2004",    1, 2'd1, 1, 0, 8'h66, 1, 10'd261, 10'd0,   8'h20, 8'h20, 0, 8'h00, 0, 8'h00);
        add("line240_w2004",    1, 2'd1, 1, 0, 8'h66, 1, 10'd240, 10'd0,   8'h20, 8'h0D, 1, 8'h66, 0, 8'h00);
        add("dot256_noclr",     1, 2'd3, 0, 0, 8'h00, 1, 10'd100, 10'd256, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00);
        add("after_dot256",     1, 2'd3, 0, 0, 8'h00, 0, 10'd100, 10'd0,   8'h00, 8'h0E, 0, 8'h00, 0, 8'h00);
        add("dot257_clr",       1, 2'd3, 0, 0, 8'h00, 1, 10'd100, 10'd257, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00);
        add("after257_w2003",   1, 2'd0, 1, 0, 8'h40, 0, 10'd100, 10'd0,   8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        add("dot320_clr",       1, 2'd3, 0, 0, 8'h00, 1, 10'd100, 10'd320, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00);
        add("after320_w2003",   1, 2'd0, 1, 0, 8'h40, 0, 10'd100, 10'd0,   8'h00, 8'h00, 0, 8'h00, 0, 8'h00);
        add("dot321_noclr",     1, 2'd3, 0, 0, 8'h00, 1, 10'd100, 10'd321, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00);
        add("norender_dot300",  1, 2'd3, 0, 0, 8'h00, 0, 10'd100, 10'd300, 8'h00, 8'h40, 0, 8'h00, 0, 8'h00);
        add("clr_beats_w2003",  1, 2'd0, 1, 0, 8'h77, 1, 10'd100, 10'd300, 8'h01, 8'h01, 0, 8'h00, 0, 8'h00);
        add("after_clr_w2003",  1, 2'd3, 0, 0, 8'h00, 0, 10'd0,   10'd0,   8'h00, 8'h00, 0, 8'h00, 0, 8'h00);

        foreach (vecs[k]) begin
            cpu_ce    = vecs[k].ce;
            reg_sel   = vecs[k].sel;
            reg_wr    = vecs[k].wr;
            reg_rd    = vecs[k].rd;
            cpu_wdata = vecs[k].wdata;
            render_en = vecs[k].ren;
            scanline  = vecs[k].line;
            x_idx     = vecs[k].dot;
            eval_addr = vecs[k].eval;
            #1;
            check({vecs[k].name, "_oam_addr"}, oam_addr, vecs[k].exp_addr);
            check({vecs[k].name, "_oam_we"}, oam_we, vecs[k].exp_we);
            check({vecs[k].name, "_eval_data"}, eval_data, oam_mem[oam_addr]);
            if (vecs[k].exp_we) check({vecs[k].name, "_oam_wdata"}, oam_wdata, vecs[k].exp_wd);
            if (vecs[k].rdchk) rd_q.push_back(vecs[k].exp_rd);
            tick();
            if (vecs[k].rdchk) begin
                if (rd_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_rdata: scoreboard empty", vecs[k].name);
                end else begin
                    check({vecs[k].name, "_cpu_rdata"}, cpu_rdata, rd_q.pop_front());
                end
            end
        end
        idle();

        check("ram_10", oam_mem[8'h10], 8'hAA);
        check("ram_11", oam_mem[8'h11], 8'hBB);
        check("ram_FF", oam_mem[8'hFF], 8'h5C);
        check("ram_02_attr", oam_mem[8'h02], ATTR_FF);
        check("ram_05_render_blocked", oam_mem[8'h05], 8'h00);
        check("ram_09_preline_blocked", oam_mem[8'h09], 8'h00);
        check("ram_0D_line240", oam_mem[8'h0D], 8'h66);

        run_dma("dma_even", 1'b0, 8'h00, 1'b0, 513);
        run_dma("dma_odd", 1'b1, 8'h80, 1'b1, 514);

        // Reset while the DMA is mid-page: stall drops at once, written bytes stay.
        write_reg(2'b00, 8'h00);
        clear_ram();
        cpu_odd   = 1'b0;
        reg_sel   = 2'b10;
        reg_wr    = 1'b1;
        cpu_wdata = 8'h02;
        tick();
        reads = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            idle();
            #1;
            if (dma_rd) reads++;
            if (reads == 20) break;
            tick();
        end
        check("rstdma_reads_seen", 16'(reads), 16'd20);
        tick();
        reset = 1'b1;
        #1;
        check("rstdma_stall", cpu_stall, 1'b0);
        check("rstdma_dma_rd", dma_rd, 1'b0);
        check("rstdma_oam_we", oam_we, 1'b0);
        check("rstdma_oam_addr", oam_addr, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        check("rstdma_kept_byte18", oam_mem[18], 8'h12 ^ 8'h3C);
        check("rstdma_no_byte19", oam_mem[19], 8'h00);
        reg_sel   = 2'b01;
        reg_wr    = 1'b1;
        cpu_wdata = 8'h99;
        #1;
        check("rstdma_cpu_we_ok", oam_we, 1'b1);
        tick();
        idle();
        check("rstdma_cpu_wrote", oam_mem[0], 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
